// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared status register, CPU mode and interrupt FSM types
package reg_pkg;

  typedef enum logic {
    MODE_USER  = 1'b0,
    MODE_SUPER = 1'b1
  } cpu_mode_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_status_t;

  // Bit layout [5]=mode, [4]=imask, [3:0]=ALU flags
  typedef struct packed {
    cpu_mode_e   mode;
    logic        imask;
    alu_status_t alu;
  } status_t;

  typedef enum logic [2:0] {
    IRQ_IDLE    = 3'd0,
    IRQ_PENDING = 3'd1,
    IRQ_ENTRY   = 3'd2,
    IRQ_SERVICE = 3'd3,
    IRQ_RETURN  = 3'd4
  } irq_state_e;

  localparam int IRQ_LINES = 4;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, bit 0 wins
module irq_prio_enc (
  input  logic [3:0] req,
  output logic [1:0] id,
  output logic       valid
);

  always_comb begin
    id    = 2'd0;
    valid = 1'b1;
    casez (req)
      4'b???1: id = 2'd0;
      4'b??10: id = 2'd1;
      4'b?100: id = 2'd2;
      4'b1000: id = 2'd3;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - single-level interrupt controller with status save/restore
module irq_ctrl
  import reg_pkg::*;
#(
  parameter logic [15:0] VECTOR_BASE   = 16'h0010,
  parameter int          VECTOR_STRIDE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  irq_lines,
  input  logic [3:0]  irq_en,
  input  status_t     status_in,
  output logic        irq_pending,
  input  logic        irq_ack,
  input  logic        reti,
  output logic [15:0] vector_out,
  output logic        vector_valid,
  output status_t     status_out,
  output logic        ld_status,
  output logic        imask_out,
  output logic        ld_imask,
  output cpu_mode_e   mode_out,
  output logic        ld_mode
);

  irq_state_e  state_q, state_d;
  logic [1:0]  irq_id_q;
  status_t     shadow_q;
  logic [1:0]  enc_id;
  logic        enc_valid;
  logic        take;
  logic [15:0] vector_calc;

  irq_prio_enc u_prio (
    .req   (irq_lines & irq_en),
    .id    (enc_id),
    .valid (enc_valid)
  );

  assign take        = !status_in.imask && enc_valid;
  assign vector_calc = VECTOR_BASE + 16'(irq_id_q) * 16'(VECTOR_STRIDE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IRQ_IDLE;
      irq_id_q <= 2'd0;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IRQ_IDLE && take)
        irq_id_q <= enc_id;
      if (state_q == IRQ_PENDING && irq_ack)
        shadow_q <= status_in;
    end
  end

  // Outputs depend only on state, so reset values appear as soon as rst forces IDLE
  always_comb begin
    state_d      = state_q;
    irq_pending  = 1'b0;
    vector_out   = 16'h0000;
    vector_valid = 1'b0;
    ld_status    = 1'b0;
    imask_out    = 1'b0;
    ld_imask     = 1'b0;
    mode_out     = MODE_USER;
    ld_mode      = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if (take) state_d = IRQ_PENDING;
      end
      IRQ_PENDING: begin
        irq_pending = 1'b1;
        if (irq_ack) state_d = IRQ_ENTRY;
      end
      IRQ_ENTRY: begin
        ld_imask     = 1'b1;
        imask_out    = 1'b1;
        ld_mode      = 1'b1;
        mode_out     = MODE_SUPER;
        vector_valid = 1'b1;
        vector_out   = vector_calc;
        state_d      = IRQ_SERVICE;
      end
      IRQ_SERVICE: begin
        if (reti) state_d = IRQ_RETURN;
      end
      IRQ_RETURN: begin
        ld_status = 1'b1;
        state_d   = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  assign status_out = shadow_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;
  import reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_lines;
  logic [3:0]  irq_en;
  status_t     status_in;
  logic        irq_pending;
  logic        irq_ack;
  logic        reti;
  logic [15:0] vector_out;
  logic        vector_valid;
  status_t     status_out;
  logic        ld_status;
  logic        imask_out;
  logic        ld_imask;
  cpu_mode_e   mode_out;
  logic        ld_mode;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  irq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .irq_lines    (irq_lines),
    .irq_en       (irq_en),
    .status_in    (status_in),
    .irq_pending  (irq_pending),
    .irq_ack      (irq_ack),
    .reti         (reti),
    .vector_out   (vector_out),
    .vector_valid (vector_valid),
    .status_out   (status_out),
    .ld_status    (ld_status),
    .imask_out    (imask_out),
    .ld_imask     (ld_imask),
    .mode_out     (mode_out),
    .ld_mode      (ld_mode)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every output at its idle/reset value; status_out compared separately
  task automatic check_quiet(input string tag);
    check({tag, ".pending"}, 32'(irq_pending), 32'd0);
    check({tag, ".vvalid"},  32'(vector_valid), 32'd0);
    check({tag, ".vout"},    32'(vector_out), 32'd0);
    check({tag, ".ldstat"},  32'(ld_status), 32'd0);
    check({tag, ".ldimask"}, 32'(ld_imask), 32'd0);
    check({tag, ".imask"},   32'(imask_out), 32'd0);
    check({tag, ".ldmode"},  32'(ld_mode), 32'd0);
    check({tag, ".mode"},    32'(mode_out), 32'(MODE_USER));
  endtask

  task automatic check_entry(input string tag, input logic [15:0] vec);
    check({tag, ".vout"},    32'(vector_out), 32'(vec));
    check({tag, ".vvalid"},  32'(vector_valid), 32'd1);
    check({tag, ".ldimask"}, 32'(ld_imask), 32'd1);
    check({tag, ".imask"},   32'(imask_out), 32'd1);
    check({tag, ".ldmode"},  32'(ld_mode), 32'd1);
    check({tag, ".mode"},    32'(mode_out), 32'(MODE_SUPER));
    check({tag, ".pending"}, 32'(irq_pending), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    irq_lines = 4'h0;
    irq_en    = 4'h0;
    status_in = '0;
    irq_ack   = 1'b0;
    reti      = 1'b0;
    step();
    step();
    check_quiet("reset");
    check("reset.status", 32'(status_out), 32'd0);
    rst = 1'b0;

    // Basic flow: line 2 -> vector 0x18
    irq_en    = 4'hF;
    irq_lines = 4'b0100;
    step();
    check("basic.pending1", 32'(irq_pending), 32'd1);
    step();
    step();
    check("basic.pending3", 32'(irq_pending), 32'd1);
    irq_ack = 1'b1;
    step();
    check_entry("basic.entry", 16'h0018);
    irq_ack   = 1'b0;
    irq_lines = 4'h0;
    step();
    check_quiet("basic.service");
    irq_ack = 1'b1;
    step();
    check_quiet("spur_ack.service");
    irq_ack = 1'b0;
    reti    = 1'b1;
    step();
    check("basic.ldstat", 32'(ld_status), 32'd1);
    check("basic.statout", 32'(status_out), 32'd0);
    reti = 1'b0;
    step();
    check_quiet("basic.idle");

    // reti in IDLE must do nothing
    reti = 1'b1;
    step();
    check_quiet("spur_reti.idle");
    reti = 1'b0;

    // Priority plus save/restore
    status_in = 6'b10_1101;
    irq_lines = 4'b1010;
    step();
    check("prio.pending", 32'(irq_pending), 32'd1);
    irq_ack = 1'b1;
    step();
    check_entry("prio.entry", 16'h0014);
    irq_ack   = 1'b0;
    status_in = 6'b01_0000;
    irq_lines = 4'b1000;
    step();
    check("prio.service_nopend", 32'(irq_pending), 32'd0);
    reti = 1'b1;
    step();
    check("save.ldstat", 32'(ld_status), 32'd1);
    check("save.statout", 32'(status_out), 32'(6'b10_1101));
    reti      = 1'b0;
    status_in = 6'b10_1101;
    step();
    check("save.ldstat_off", 32'(ld_status), 32'd0);
    check("prio.idle_nopend", 32'(irq_pending), 32'd0);
    step();
    check("prio.line3_pend", 32'(irq_pending), 32'd1);

    // Request dropped during PENDING keeps its id
    irq_lines = 4'h0;
    step();
    check("drop.pending", 32'(irq_pending), 32'd1);
    irq_ack = 1'b1;
    step();
    check_entry("drop.entry", 16'h001C);
    irq_ack = 1'b0;
    step();
    reti = 1'b1;
    step();
    reti = 1'b0;
    step();
    check_quiet("drop.idle");

    // Masking by imask and by irq_en
    status_in = 6'b01_0000;
    irq_lines = 4'hF;
    for (int i = 0; i < 20; i++) begin
      step();
      check("mask.imask", 32'(irq_pending), 32'd0);
    end
    status_in = 6'b00_0000;
    irq_en    = 4'h0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("mask.en", 32'(irq_pending), 32'd0);
    end

    // Reset in SERVICE
    irq_en    = 4'hF;
    irq_lines = 4'b0001;
    status_in = 6'b10_1101;
    step();
    irq_ack = 1'b1;
    step();
    check_entry("rst.entry", 16'h0010);
    irq_ack = 1'b0;
    step();
    check("rst.shadow_before", 32'(status_out), 32'(6'b10_1101));
    #2;
    rst = 1'b1;
    #1;
    check_quiet("rst.async");
    check("rst.async.status", 32'(status_out), 32'd0);
    #2;
    rst = 1'b0;
    step();
    check("rst.next_pending", 32'(irq_pending), 32'd1);
    irq_ack = 1'b1;
    step();
    check_entry("rst.next_entry", 16'h0010);
    irq_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
